// File: rtl/uart_angle_rx.sv
// 8N1 UART receiver that decodes CR/LF-terminated ASCII angle commands ("0", "90", "180")
// into a servo PWM compare value, with per-byte and per-command strobes.
module uart_angle_rx #(
  parameter int baud_rate_p        = 5208,
  parameter int data_length_p      = 17,
  parameter int uart_data_length_p = 8,
  parameter int duty_0_p           = 24999,
  parameter int duty_90_p          = 74999,
  parameter int duty_180_p         = 124999
) (
  input  logic                          Clk_i,
  input  logic                          Reset_i,
  input  logic                          Rx_i,
  output logic [uart_data_length_p-1:0] Byte_o,
  output logic                          Byte_valid_o,
  output logic                          Frame_err_o,
  output logic [data_length_p-1:0]      Duty_o,
  output logic                          Duty_valid_o,
  output logic                          Cmd_err_o
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge
  // START | checking start bit at mid-bit
  // DATA  | sampling data bits, LSB first
  // STOP  | sampling stop bit
  // BREAK | stop bit was low, waiting for line to return high
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_t;

  localparam int CNT_W = $clog2(baud_rate_p);
  localparam int IDX_W = $clog2(uart_data_length_p);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(baud_rate_p / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(baud_rate_p - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(uart_data_length_p - 1);

  rx_state_t                     state_q, state_d;
  logic                          rx_meta, rx_sync;
  logic [CNT_W-1:0]              cnt_q;
  logic [IDX_W-1:0]              bit_idx_q;
  logic [uart_data_length_p-1:0] shift_q;
  logic                          cnt_clr, shift_en, byte_done, frame_bad;

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_d = ST_START;
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_clr = 1'b1;
          state_d = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_sync) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      Byte_o       <= '0;
      Byte_valid_o <= 1'b0;
      Frame_err_o  <= 1'b0;
    end else begin
      rx_meta <= Rx_i;
      rx_sync <= rx_meta;
      state_q <= state_d;
      if (cnt_clr || state_q == ST_IDLE || state_q == ST_BREAK) cnt_q <= '0;
      else cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_START) bit_idx_q <= '0;
      else if (shift_en) bit_idx_q <= bit_idx_q + 1'b1;
      if (shift_en) shift_q <= {rx_sync, shift_q[uart_data_length_p-1:1]};
      if (byte_done) Byte_o <= shift_q;
      Byte_valid_o <= byte_done;
      Frame_err_o  <= frame_bad;
    end
  end

  // Command parser, fed by the registered byte/frame-error strobes.
  logic [9:0]  acc_q;
  logic [1:0]  dcnt_q;
  logic        bad_q;
  logic [13:0] acc_mul;
  logic        is_digit, is_term;

  assign is_digit = (Byte_o >= 8'h30) && (Byte_o <= 8'h39);
  assign is_term  = (Byte_o == 8'h0D) || (Byte_o == 8'h0A);
  assign acc_mul  = 14'(acc_q) * 14'd10 + 14'(Byte_o[3:0]);

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      acc_q        <= '0;
      dcnt_q       <= '0;
      bad_q        <= 1'b0;
      Duty_o       <= data_length_p'(duty_90_p);
      Duty_valid_o <= 1'b0;
      Cmd_err_o    <= 1'b0;
    end else begin
      Duty_valid_o <= 1'b0;
      Cmd_err_o    <= 1'b0;
      if (Frame_err_o) begin
        bad_q <= 1'b1;
      end else if (Byte_valid_o) begin
        if (is_term) begin
          // A bare terminator (e.g. the LF of CR LF) is not a command.
          if (dcnt_q != 2'd0 || bad_q) begin
            if (!bad_q && acc_q == 10'd0) begin
              Duty_o       <= data_length_p'(duty_0_p);
              Duty_valid_o <= 1'b1;
            end else if (!bad_q && acc_q == 10'd90) begin
              Duty_o       <= data_length_p'(duty_90_p);
              Duty_valid_o <= 1'b1;
            end else if (!bad_q && acc_q == 10'd180) begin
              Duty_o       <= data_length_p'(duty_180_p);
              Duty_valid_o <= 1'b1;
            end else begin
              Cmd_err_o <= 1'b1;
            end
          end
          acc_q  <= '0;
          dcnt_q <= '0;
          bad_q  <= 1'b0;
        end else if (is_digit) begin
          if (dcnt_q == 2'd3) begin
            bad_q <= 1'b1;
          end else begin
            acc_q  <= acc_mul[9:0];
            dcnt_q <= dcnt_q + 2'd1;
          end
        end else begin
          bad_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_angle_rx.md
Name: uart_angle_rx

Overview:
- UART receiver for the servo PWM path: 8N1 serial input at 9600 baud from a 50 MHz clock.
- Decodes ASCII angle commands "0", "90" or "180", each terminated by CR or LF.
- Drives the PWM compare value (24999 / 74999 / 124999) to the servo PWM generator, with a one-cycle update strobe.
- Also exposes every received byte and per-byte and per-command error strobes.

Parameters:
- baud_rate_p, 5208, clock cycles per bit (50e6/9600); must be ≥ 4; the bench may override it to a small value.
- data_length_p, 17, width of the PWM compare value.
- uart_data_length_p, 8, data bits per frame.
- duty_0_p, 24999, compare value for 0 degrees (0.5 ms).
- duty_90_p, 74999, compare value for 90 degrees (1.5 ms).
- duty_180_p, 124999, compare value for 180 degrees (2.5 ms).

Ports:
- Clk_i  input  1  system clock, 50 MHz.
- Reset_i  input  1  reset, synchronous and active-high.
- Rx_i  input  1  serial line (idle high), asynchronous to Clk_i.
- Byte_o  output  8  last correctly framed byte.
- Byte_valid_o  output  1  one-cycle strobe; Byte_o is new.
- Frame_err_o  output  1  one-cycle strobe; stop bit sampled low.
- Duty_o  output  data_length_p  PWM compare value for the PWM generator.
- Duty_valid_o  output  1  one-cycle strobe; Duty_o was updated.
- Cmd_err_o  output  1  one-cycle strobe; terminated command rejected.

Behaviour:
- One clock, Clk_i. All registers reset synchronously while Reset_i=1.
- Reset values: Byte_o=0, Byte_valid_o=0, Frame_err_o=0, Duty_o=duty_90_p (servo centred), Duty_valid_o=0, Cmd_err_o=0.
- Reset values (internal): rx FSM=IDLE, parser cleared.
- Reset mid-frame or mid-command abandons it. Nothing is emitted for the abandoned data.
- Rx_i passes through a 2-FF synchroniser (sync value resets to 1). All sampling uses the synchronised signal.
- Rx FSM states: IDLE, START, DATA, STOP, BREAK. Baud counter runs 0..baud_rate_p-1.
  - IDLE: synchronised Rx=0 → START, counter cleared.
  - START: at count baud_rate_p/2 (integer division), sample the line.
    - Sample 0 → DATA, counter cleared, bit index 0.
    - Sample 1 → IDLE (glitch rejected, nothing emitted).
  - DATA: every baud_rate_p cycles, sample one bit into the shift register, LSB first. After bit 7 is sampled → STOP.
  - STOP: after baud_rate_p cycles, sample the line.
    - Sample 1: Byte_o loaded and Byte_valid_o=1 on the next cycle; → IDLE.
    - Sample 0: Frame_err_o=1 on the next cycle; Byte_o unchanged; byte discarded; → BREAK.
  - BREAK: wait until synchronised Rx=1 → IDLE. A held-low line produces exactly one Frame_err_o.
- Parser, acting on each Byte_valid_o byte. State: 10-bit accumulator, 2-bit digit count, bad flag.
  - '0'..'9' (0x30..0x39) with count<3: acc=acc*10+digit, count+1.
  - A digit with count=3 sets bad.
  - Any other non-terminator byte sets bad.
  - A frame error sets bad.
  - Terminator 0x0D or 0x0A with count=0 and bad=0: ignored silently, so CR LF yields one command.
  - Terminator, otherwise: evaluate the command.
    - Accepted if bad=0 and acc ∈ {0, 90, 180}. Leading zeros are legal ("090" = 90).
    - Accepted: Duty_o takes the mapped duty value and Duty_valid_o=1.
    - Rejected: Cmd_err_o=1 and Duty_o is held.
  - Evaluation timing: on the cycle after the Byte_valid_o of the terminator.
  - The parser clears after every terminator.
- Duty_valid_o fires even when the new value equals the old one.
- Strobes never overlap within one output class and are each exactly 1 cycle wide.
- Worst-case latency, start edge to Byte_valid_o: 2 (sync) + baud_rate_p/2 + 9·baud_rate_p + 1 cycles.

Test Plan:
- Idle line held high for 100 000 cycles after reset → all strobes 0, Duty_o=74999, Byte_o=0.
- Send '1','8','0',0x0D,0x0A → Byte_valid_o pulses 5 times with Byte_o=0x31,0x38,0x30,0x0D,0x0A. Exactly one Duty_valid_o, Duty_o=124999, no Cmd_err_o.
- Send "0\r" then "90\n" → Duty_o=24999, then 74999, with two Duty_valid_o pulses.
- Send "45\r", "1800\r", "9x\r" → three Cmd_err_o pulses, Duty_o unchanged (74999), no Duty_valid_o.
- Frame with stop bit 0 (byte 0x39), then line high, then "0\r":
  - Frame_err_o pulses once, no Byte_valid_o for 0x39.
  - "0\r" is rejected (bad set): Cmd_err_o.
  - A following "0\r" gives Duty_o=24999.
- Low glitch of baud_rate_p/4 cycles → no START completion, no strobes.
- Reset_i=1 for one cycle in the middle of bit 4 of '9' after a preceding '9' → Duty_o=74999 and no strobes; a following clean "180\r" gives Duty_o=124999.
